// File: rtl/ce_ctrl.sv
// Clock-enable controller: divides in_sys_clk by a runtime divisor and grants each tick to one requester, round-robin.
// Latency: out_tick/out_ce/out_miss are registered one cycle after the wrap cycle; first tick is div_q cycles after the first RUN cycle.
// Backpressure: out_cfg_ready drops while a shadow divisor is pending and returns on the wrap that applies it (or on stop).
// Optional feature: define CE_CTRL_MISS_CNT_EN to build the saturating missed-tick counter; otherwise out_miss_cnt is tied to 0.
module ce_ctrl #(
    parameter int DIV_W = 8,
    parameter int N_CH  = 4
) (
    input  logic             in_sys_clk,
    input  logic             in_rst_n,
    input  logic             in_run,
    input  logic             in_cfg_valid,
    input  logic [DIV_W-1:0] in_cfg_div,
    output logic             out_cfg_ready,
    input  logic [N_CH-1:0]  in_req,
    output logic [N_CH-1:0]  out_ce,
    output logic             out_tick,
    output logic             out_miss,
    output logic [15:0]      out_miss_cnt
);

    localparam int PTR_W = (N_CH > 1) ? $clog2(N_CH) : 1;

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_RUN  = 2'd1,
        S_PEND = 2'd2
    } state_t;

    state_t             r_state;
    logic [DIV_W-1:0]   r_cnt;
    logic [DIV_W-1:0]   r_div;
    logic [DIV_W-1:0]   r_shadow;
    logic [PTR_W-1:0]   r_ptr;
    logic               r_cfg_rdy;
    logic               r_tick;
    logic [N_CH-1:0]    r_ce;
    logic               r_miss;

    logic               w_counting;
    logic               w_wrap;
    logic               w_tick_en;
    logic               w_cfg_xfer;
    logic [DIV_W-1:0]   w_cfg_d;
    logic               w_gnt_vld;
    logic [PTR_W-1:0]   w_gnt_idx;
    logic [N_CH-1:0]    w_gnt_oh;
    logic [PTR_W-1:0]   w_cand;

    assign w_counting = (r_state != S_IDLE);
    assign w_wrap     = w_counting && (r_cnt == (r_div - DIV_W'(1)));
    // A wrap while in_run is already low must not produce a tick: stopping means no further ticks.
    assign w_tick_en  = w_wrap && in_run;
    assign w_cfg_xfer = in_cfg_valid && r_cfg_rdy;
    // A divisor of 0 has no meaning; treat it as the fastest rate.
    assign w_cfg_d    = (in_cfg_div == '0) ? DIV_W'(1) : in_cfg_div;

    // Round-robin search starting one past the last granted channel.
    always_comb begin
        w_gnt_vld = 1'b0;
        w_gnt_idx = r_ptr;
        w_gnt_oh  = '0;
        w_cand    = '0;
        for (int i = 1; i <= N_CH; i++) begin
            w_cand = PTR_W'((int'(r_ptr) + i) % N_CH);
            if (!w_gnt_vld && in_req[w_cand]) begin
                w_gnt_vld = 1'b1;
                w_gnt_idx = w_cand;
                w_gnt_oh  = N_CH'(1) << w_cand;
            end
        end
    end

    // FSM, tick counter, divisor/shadow registers and registered tick/grant outputs.
    always_ff @(posedge in_sys_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_state   <= S_IDLE;
            r_cnt     <= '0;
            r_div     <= DIV_W'(2);
            r_shadow  <= '0;
            r_ptr     <= PTR_W'(N_CH - 1);
            r_cfg_rdy <= 1'b1;
            r_tick    <= 1'b0;
            r_ce      <= '0;
            r_miss    <= 1'b0;
        end else begin
            r_tick <= w_tick_en;
            r_ce   <= '0;
            r_miss <= 1'b0;
            if (w_tick_en) begin
                if (w_gnt_vld) begin
                    r_ce  <= w_gnt_oh;
                    r_ptr <= w_gnt_idx;
                end else begin
                    r_miss <= 1'b1;
                end
            end

            case (r_state)
                S_IDLE: begin
                    r_cnt     <= '0;
                    r_cfg_rdy <= 1'b1;
                    // Nothing is counting, so a new divisor can take effect at once.
                    if (w_cfg_xfer) begin
                        r_div <= w_cfg_d;
                    end
                    if (in_run) begin
                        r_state <= S_RUN;
                    end
                end
                S_RUN: begin
                    if (!in_run) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_cfg_rdy <= 1'b1;
                    end else begin
                        r_cnt <= w_wrap ? '0 : (r_cnt + DIV_W'(1));
                        // Even on a wrap cycle the new value only lands in the shadow; it applies at the next wrap.
                        if (w_cfg_xfer) begin
                            r_shadow  <= w_cfg_d;
                            r_state   <= S_PEND;
                            r_cfg_rdy <= 1'b0;
                        end
                    end
                end
                S_PEND: begin
                    if (!in_run) begin
                        r_state   <= S_IDLE;
                        r_cnt     <= '0;
                        r_div     <= r_shadow;
                        r_cfg_rdy <= 1'b1;
                    end else begin
                        r_cnt <= w_wrap ? '0 : (r_cnt + DIV_W'(1));
                        // The current period finishes on the old divisor; the next one uses the shadow.
                        if (w_wrap) begin
                            r_div     <= r_shadow;
                            r_state   <= S_RUN;
                            r_cfg_rdy <= 1'b1;
                        end
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_cnt     <= '0;
                    r_cfg_rdy <= 1'b1;
                end
            endcase
        end
    end

    assign out_cfg_ready = r_cfg_rdy;
    assign out_tick      = r_tick;
    assign out_ce        = r_ce;
    assign out_miss      = r_miss;

`ifdef CE_CTRL_MISS_CNT_EN
    logic [15:0] r_miss_cnt;

    // Saturating count of ticks that found no requester; only reset clears it.
    always_ff @(posedge in_sys_clk or negedge in_rst_n) begin
        if (!in_rst_n) begin
            r_miss_cnt <= '0;
        end else if (r_miss && (r_miss_cnt != 16'hFFFF)) begin
            r_miss_cnt <= r_miss_cnt + 16'd1;
        end
    end

    assign out_miss_cnt = r_miss_cnt;
`else
    assign out_miss_cnt = 16'h0000;
`endif

endmodule

// File: tb/tb_ce_ctrl.sv
// Directed bench for ce_ctrl: expected ticks (cycle, grant, miss) are queued as stimulus is applied.
// A negedge monitor pops one entry per observed tick; quiet cycles must show no grant and no miss.
// Scenarios: IDLE load, mid-period reconfig, missed ticks, D=1, stop with pending shadow, reset in PEND.
module tb_ce_ctrl;

    localparam int DIV_W = 8;
    localparam int N_CH  = 4;

    logic             clk;
    logic             rst_n;
    logic             run;
    logic             cfg_vld;
    logic [DIV_W-1:0] cfg_div;
    logic             cfg_rdy;
    logic [N_CH-1:0]  req;
    logic [N_CH-1:0]  ce;
    logic             tick;
    logic             miss;
    logic [15:0]      miss_cnt;

    typedef struct packed {
        int          cyc;
        logic [3:0]  ce;
        logic        miss;
    } exp_t;

    exp_t sb[$];
    int   cyc;
    int   ncmp;
    int   nfail;

    ce_ctrl #(.DIV_W(DIV_W), .N_CH(N_CH)) dut (
        .in_sys_clk    (clk),
        .in_rst_n      (rst_n),
        .in_run        (run),
        .in_cfg_valid  (cfg_vld),
        .in_cfg_div    (cfg_div),
        .out_cfg_ready (cfg_rdy),
        .in_req        (req),
        .out_ce        (ce),
        .out_tick      (tick),
        .out_miss      (miss),
        .out_miss_cnt  (miss_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        ncmp++;
        assert (obs === exp_v) else begin
            nfail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp_v);
        end
    endtask

    task automatic push(input int c, input logic [3:0] e_ce, input logic e_miss);
        exp_t e;
        e.cyc  = c;
        e.ce   = e_ce;
        e.miss = e_miss;
        sb.push_back(e);
    endtask

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic wait_cyc(input int c);
        while (cyc < c) step(1);
    endtask

    // Scoreboard consumer: every tick must match the head of the expectation queue.
    always @(negedge clk) begin
        if (rst_n === 1'b1) begin
            if (tick === 1'b1) begin
                chk("tick_expected", 32'(sb.size() != 0), 32'd1);
                if (sb.size() != 0) begin
                    exp_t e;
                    e = sb.pop_front();
                    chk("tick_cycle", cyc, e.cyc);
                    chk("tick_ce", 32'(ce), 32'(e.ce));
                    chk("tick_miss", 32'(miss), 32'(e.miss));
                end
            end else begin
                chk("quiet_ce_miss", 32'({ce, miss}), 32'd0);
            end
        end
    end

    initial begin
        int k, t, u, v, w, x, y, z;
        ncmp    = 0;
        nfail   = 0;
        cyc     = 0;
        rst_n   = 1'b0;
        run     = 1'b0;
        cfg_vld = 1'b0;
        cfg_div = '0;
        req     = '0;

        // Reset state
        step(2);
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_ce", 32'(ce), 32'd0);
        chk("rst_miss", 32'(miss), 32'd0);
        chk("rst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("rst_cfg_rdy", 32'(cfg_rdy), 32'd1);
        rst_n = 1'b1;
        step(1);

        // D=4 loaded in IDLE, round-robin over all four channels
        cfg_vld = 1'b1;
        cfg_div = 8'd4;
        step(1);
        cfg_vld = 1'b0;
        chk("idle_cfg_rdy", 32'(cfg_rdy), 32'd1);
        req = 4'b1111;
        run = 1'b1;
        k   = cyc;
        for (int m = 1; m <= 5; m++) push(k + 1 + 4 * m, 4'(1 << ((m - 1) % 4)), 1'b0);
        t = k + 21;

        // Mid-period reconfig to D=7: old period completes, then 7-cycle periods
        wait_cyc(t + 1);
        cfg_vld = 1'b1;
        cfg_div = 8'd7;
        push(t + 4, 4'b0010, 1'b0);
        push(t + 11, 4'b0100, 1'b0);
        push(t + 18, 4'b1000, 1'b0);
        step(1);
        cfg_vld = 1'b0;
        chk("pend_rdy_a", 32'(cfg_rdy), 32'd0);
        step(1);
        chk("pend_rdy_b", 32'(cfg_rdy), 32'd0);
        step(1);
        chk("wrap_rdy", 32'(cfg_rdy), 32'd1);

        // Three missed ticks, then a single requester on channel 2
        u = t + 18;
        wait_cyc(u);
        req = 4'b0000;
        push(u + 7, 4'b0000, 1'b1);
        push(u + 14, 4'b0000, 1'b1);
        push(u + 21, 4'b0000, 1'b1);
        wait_cyc(u + 21);
        req = 4'b0100;
        push(u + 28, 4'b0100, 1'b0);
        wait_cyc(u + 28);
`ifdef CE_CTRL_MISS_CNT_EN
        chk("miss_cnt", 32'(miss_cnt), 32'd3);
`else
        chk("miss_cnt", 32'(miss_cnt), 32'd0);
`endif

        // D=1 with channels 1 and 3 requesting: tick every cycle, grants alternate
        req     = 4'b1010;
        cfg_vld = 1'b1;
        cfg_div = 8'd1;
        push(u + 35, 4'b1000, 1'b0);
        for (int j = 0; j <= 8; j++) push(u + 36 + j, (j % 2 == 0) ? 4'b0010 : 4'b1000, 1'b0);
        step(1);
        cfg_vld = 1'b0;
        chk("d1_pend_rdy", 32'(cfg_rdy), 32'd0);

        // Stop, load D=5 in IDLE, restart; then stop with a D=3 shadow pending
        v = u + 44;
        wait_cyc(v);
        run = 1'b0;
        step(1);
        cfg_vld = 1'b1;
        cfg_div = 8'd5;
        step(1);
        cfg_vld = 1'b0;
        req = 4'b1111;
        run = 1'b1;
        push(v + 8, 4'b0100, 1'b0);
        w = v + 8;
        wait_cyc(w + 1);
        cfg_vld = 1'b1;
        cfg_div = 8'd3;
        step(1);
        cfg_vld = 1'b0;
        chk("stop_pend_rdy", 32'(cfg_rdy), 32'd0);
        step(1);
        run = 1'b0;
        step(1);
        chk("stop_cfg_rdy", 32'(cfg_rdy), 32'd1);
        step(4);
        run = 1'b1;
        x = cyc;
        push(x + 4, 4'b1000, 1'b0);
        push(x + 7, 4'b0001, 1'b0);

        // Reset pulse while a D=6 shadow is pending: shadow discarded, period back to 2
        y = x + 7;
        wait_cyc(y);
        cfg_vld = 1'b1;
        cfg_div = 8'd6;
        step(1);
        cfg_vld = 1'b0;
        chk("rst_pend_rdy", 32'(cfg_rdy), 32'd0);
        chk("sb_drained_pre_rst", 32'(sb.size()), 32'd0);
        #2;
        rst_n = 1'b0;
        #1;
        chk("arst_tick", 32'(tick), 32'd0);
        chk("arst_ce", 32'(ce), 32'd0);
        chk("arst_miss", 32'(miss), 32'd0);
        chk("arst_miss_cnt", 32'(miss_cnt), 32'd0);
        chk("arst_cfg_rdy", 32'(cfg_rdy), 32'd1);
        step(2);
        z = cyc;
        rst_n = 1'b1;
        push(z + 3, 4'b0001, 1'b0);
        push(z + 5, 4'b0010, 1'b0);
        push(z + 7, 4'b0100, 1'b0);
        wait_cyc(z + 7);
        step(1);
        run = 1'b0;
        step(3);
        chk("sb_drained_end", 32'(sb.size()), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", ncmp, nfail);
        $finish;
    end

endmodule
